// File: rtl/fg_defs.sv
`default_nettype none
// ============================================================================
//  Package     : fg_defs
//  Description : Shared definitions for the function-generator blocks:
//                ramp controller state encodings and step counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package fg_defs;

    // Controller state encoding
    localparam int                 c_STATE_W  = 1;
    localparam logic [c_STATE_W-1:0] c_SETTLED = 1'b0;
    localparam logic [c_STATE_W-1:0] c_RAMP    = 1'b1;

    // Width of the per-step cycle counter; bounds STEP_CYCLES to 2^16-1
    localparam int                 c_CNT_W    = 16;

endpackage : fg_defs
`default_nettype wire

// File: rtl/amplitude_scaler_if.sv
`default_nettype none
// ============================================================================
//  Interface   : amplitude_scaler_if
//  Description : Sample stream, attenuation control and status signals of
//                the amplitude scaler. master = stimulus side, slave = scaler.
//  Revision    : 1.0  initial release
// ============================================================================
interface amplitude_scaler_if #(
    parameter int DATA_W  = 8,
    parameter int SHIFT_W = 2
);
    logic [DATA_W-1:0]  data_in;
    logic               in_valid;
    logic [SHIFT_W-1:0] amp_sel;
    logic               ramp_en;
    logic [DATA_W-1:0]  data_out;
    logic               out_valid;
    logic [SHIFT_W-1:0] cur_shift;
    logic               settled;

    modport master (
        output data_in, in_valid, amp_sel, ramp_en,
        input  data_out, out_valid, cur_shift, settled
    );

    modport slave (
        input  data_in, in_valid, amp_sel, ramp_en,
        output data_out, out_valid, cur_shift, settled
    );
endinterface : amplitude_scaler_if
`default_nettype wire

// File: rtl/shift_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_ramp_ctrl
//  Description : Attenuation controller. Either jumps straight to the target
//                shift or glides one step every STEP_CYCLES clocks, steering
//                toward the live target at every step point.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_ramp_ctrl
    import fg_defs::*;
#(
    parameter int SHIFT_W     = 2,
    parameter int STEP_CYCLES = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic [SHIFT_W-1:0] amp_sel,
    input  wire logic               ramp_en,
    output logic      [SHIFT_W-1:0] cur_shift,
    output logic                    settled
);

    localparam logic [c_CNT_W-1:0] c_STEP_LAST = c_CNT_W'(STEP_CYCLES - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [SHIFT_W-1:0]   r_cur;
    logic [SHIFT_W-1:0]   w_cur_nxt;
    logic [SHIFT_W-1:0]   w_cur_step;

    // One step toward the target; only used when target differs, so never wraps
    assign w_cur_step = (amp_sel > r_cur) ? r_cur + SHIFT_W'(1) : r_cur - SHIFT_W'(1);
    assign cur_shift  = r_cur;

    // State register: controller state, step counter and applied shift
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_SETTLED;
            r_cnt   <= '0;
            r_cur   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cur   <= w_cur_nxt;
        end
    end

    // Next-state logic: jump, start/continue a glide, or abort a glide
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cur_nxt   = r_cur;
        case (r_state)
            c_SETTLED: begin
                if (amp_sel != r_cur) begin
                    if (ramp_en) begin
                        w_state_nxt = c_RAMP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cur_nxt   = amp_sel;
                    end
                end
            end
            c_RAMP: begin
                if (!ramp_en) begin
                    // Glide abandoned: snap to the target
                    w_cur_nxt   = amp_sel;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_SETTLED;
                end else if (r_cnt == c_STEP_LAST) begin
                    w_cnt_nxt = '0;
                    if (amp_sel == r_cur) begin
                        w_state_nxt = c_SETTLED;
                    end else begin
                        w_cur_nxt = w_cur_step;
                        if (w_cur_step == amp_sel) begin
                            w_state_nxt = c_SETTLED;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_SETTLED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: settled only when idle and already at the target
    always_comb begin
        settled = (r_state == c_SETTLED) && (r_cur == amp_sel);
    end

endmodule : shift_ramp_ctrl
`default_nettype wire

// File: rtl/amplitude_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : amplitude_scaler
//  Description : Attenuates a sample stream by a right shift whose amount is
//                set directly or glided by shift_ramp_ctrl. Output sample is
//                registered with one cycle of latency.
//  Revision    : 1.0  initial release
// ============================================================================
module amplitude_scaler #(
    parameter int DATA_W      = 8,
    parameter int SHIFT_W     = 2,
    parameter int STEP_CYCLES = 4,
    parameter int SIGNED_MODE = 0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    amplitude_scaler_if.slave  bus
);

    logic [SHIFT_W-1:0] w_cur_shift;
    logic               w_settled;
    logic [DATA_W-1:0]  w_shifted;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_out_valid;

    shift_ramp_ctrl #(
        .SHIFT_W     (SHIFT_W),
        .STEP_CYCLES (STEP_CYCLES)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .amp_sel   (bus.amp_sel),
        .ramp_en   (bus.ramp_en),
        .cur_shift (w_cur_shift),
        .settled   (w_settled)
    );

    // The sample always sees the shift in force before the edge
    if (SIGNED_MODE != 0) begin : g_signed
        assign w_shifted = $unsigned($signed(bus.data_in) >>> w_cur_shift);
    end else begin : g_unsigned
        assign w_shifted = bus.data_in >> w_cur_shift;
    end

    // Output sample register and valid pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_data_out <= w_shifted;
            end
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.out_valid = r_out_valid;
    assign bus.cur_shift = w_cur_shift;
    assign bus.settled   = w_settled;

endmodule : amplitude_scaler
`default_nettype wire

// File: tb/tb_amplitude_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amplitude_scaler
//  Description : Self-checking bench for amplitude_scaler. An unsigned and a
//                signed instance see identical stimulus; both are compared
//                every cycle against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_amplitude_scaler;

    localparam int DATA_W      = 8;
    localparam int SHIFT_W     = 2;
    localparam int STEP_CYCLES = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [DATA_W-1:0]  data_in;
    logic               in_valid;
    logic [SHIFT_W-1:0] amp_sel;
    logic               ramp_en;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int   m_cur;
    bit   m_ramp;
    int   m_age;
    logic [DATA_W-1:0] m_dout_u;
    logic [DATA_W-1:0] m_dout_s;
    bit   m_ov;

    amplitude_scaler_if #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) bus_u ();
    amplitude_scaler_if #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) bus_s ();

    assign bus_u.data_in  = data_in;
    assign bus_u.in_valid = in_valid;
    assign bus_u.amp_sel  = amp_sel;
    assign bus_u.ramp_en  = ramp_en;
    assign bus_s.data_in  = data_in;
    assign bus_s.in_valid = in_valid;
    assign bus_s.amp_sel  = amp_sel;
    assign bus_s.ramp_en  = ramp_en;

    amplitude_scaler #(
        .DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .STEP_CYCLES(STEP_CYCLES), .SIGNED_MODE(0)
    ) u_dut_u (
        .clk (clk), .rst_n (rst_n), .bus (bus_u.slave)
    );

    amplitude_scaler #(
        .DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .STEP_CYCLES(STEP_CYCLES), .SIGNED_MODE(1)
    ) u_dut_s (
        .clk (clk), .rst_n (rst_n), .bus (bus_s.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge, using the values presented before it
    task automatic model_edge();
        int v, d, q;
        if (!rst_n) begin
            m_dout_u = '0;
            m_dout_s = '0;
            m_ov     = 1'b0;
            m_cur    = 0;
            m_ramp   = 1'b0;
            m_age    = 0;
            return;
        end
        d = 1 << m_cur;
        if (in_valid) begin
            m_dout_u = DATA_W'(int'(data_in) / d);
            v = int'($signed(data_in));
            q = (v >= 0) ? v / d : -((-v + d - 1) / d);   // floor division
            m_dout_s = q[DATA_W-1:0];
        end
        m_ov = in_valid;
        if (!m_ramp) begin
            if (int'(amp_sel) != m_cur) begin
                if (ramp_en) begin
                    m_ramp = 1'b1;
                    m_age  = 0;
                end else begin
                    m_cur = int'(amp_sel);
                end
            end
        end else if (!ramp_en) begin
            m_cur  = int'(amp_sel);
            m_ramp = 1'b0;
            m_age  = 0;
        end else begin
            m_age++;
            if (m_age == STEP_CYCLES) begin
                m_age = 0;
                if (int'(amp_sel) == m_cur) begin
                    m_ramp = 1'b0;
                end else begin
                    m_cur = m_cur + ((int'(amp_sel) > m_cur) ? 1 : -1);
                    if (m_cur == int'(amp_sel)) m_ramp = 1'b0;
                end
            end
        end
    endtask

    // Advance one clock, update the model, then compare both instances
    task automatic step();
        logic exp_settled;
        @(posedge clk);
        model_edge();
        #1;
        exp_settled = !m_ramp && (m_cur == int'(amp_sel));
        chk("dout_u",    32'(bus_u.data_out),  32'(m_dout_u));
        chk("dout_s",    32'(bus_s.data_out),  32'(m_dout_s));
        chk("ov_u",      32'(bus_u.out_valid), 32'(m_ov));
        chk("ov_s",      32'(bus_s.out_valid), 32'(m_ov));
        chk("cur_u",     32'(bus_u.cur_shift), 32'(m_cur));
        chk("cur_s",     32'(bus_s.cur_shift), 32'(m_cur));
        chk("settled_u", 32'(bus_u.settled),   32'(exp_settled));
        chk("settled_s", 32'(bus_s.settled),   32'(exp_settled));
    endtask

    initial begin
        int prev;
        int diff;
        bit hit;

        rst_n = 1'b0; data_in = '0; in_valid = 1'b0; amp_sel = '0; ramp_en = 1'b0;
        m_cur = 0; m_ramp = 0; m_age = 0; m_dout_u = '0; m_dout_s = '0; m_ov = 0;

        // Reset state
        step(); step();
        chk("rst_dout",    32'(bus_u.data_out),  32'h0);
        chk("rst_ov",      32'(bus_u.out_valid), 32'h0);
        chk("rst_cur",     32'(bus_u.cur_shift), 32'h0);
        chk("rst_settled", 32'(bus_u.settled),   32'h1);

        // Pass-through at shift 0
        rst_n = 1'b1; in_valid = 1'b1; data_in = 8'hC8; amp_sel = 2'd0;
        step();
        chk("pass_dout", 32'(bus_u.data_out), 32'hC8);
        chk("pass_ov",   32'(bus_u.out_valid), 32'h1);
        chk("pass_set",  32'(bus_u.settled),  32'h1);

        // Direct jump to shift 3
        amp_sel = 2'd3;
        step();
        chk("jump_cur", 32'(bus_u.cur_shift), 32'd3);
        step();
        chk("jump_dout_u", 32'(bus_u.data_out), 32'h19);
        chk("jump_dout_s", 32'(bus_s.data_out), 32'hF9);

        // Glide 0 -> 3
        amp_sel = 2'd0; step();
        in_valid = 1'b0; ramp_en = 1'b1; amp_sel = 2'd3;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (i == 5)  chk("glide_1", 32'(bus_u.cur_shift), 32'd1);
            if (i == 9)  chk("glide_2", 32'(bus_u.cur_shift), 32'd2);
            if (i == 12) chk("glide_notset", 32'(bus_u.settled), 32'd0);
            if (i == 13) begin
                chk("glide_3",   32'(bus_u.cur_shift), 32'd3);
                chk("glide_set", 32'(bus_u.settled),   32'd1);
            end
        end

        // Shift 2 of 0x80, unsigned vs signed
        ramp_en = 1'b0; amp_sel = 2'd2; in_valid = 1'b1; data_in = 8'h80;
        step(); step();
        chk("sh2_u", 32'(bus_u.data_out), 32'h20);
        chk("sh2_s", 32'(bus_s.data_out), 32'hE0);

        // Glide 0 -> 3 retargeted to 1 at shift 2
        amp_sel = 2'd0; in_valid = 1'b0; step();
        ramp_en = 1'b1; amp_sel = 2'd3;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (bus_u.cur_shift == 2'd2) hit = 1'b1;
        end
        chk("retgt_reach2", 32'(hit), 32'd1);
        amp_sel = 2'd1;
        hit = 1'b0;
        prev = int'(bus_u.cur_shift);
        for (int i = 0; i < 8 && !hit; i++) begin
            step();
            diff = int'(bus_u.cur_shift) - prev;
            chk("retgt_stepsize", 32'((diff <= 1) && (diff >= -1)), 32'd1);
            prev = int'(bus_u.cur_shift);
            if (bus_u.cur_shift == 2'd1) hit = 1'b1;
        end
        chk("retgt_reach1", 32'(hit), 32'd1);
        chk("retgt_set",    32'(bus_u.settled), 32'd1);

        // Reset in the middle of a glide
        amp_sel = 2'd0; ramp_en = 1'b0; step();
        ramp_en = 1'b1; amp_sel = 2'd3;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (bus_u.cur_shift == 2'd2) hit = 1'b1;
        end
        chk("mid_reach2", 32'(hit), 32'd1);
        rst_n = 1'b0; in_valid = 1'b1; data_in = 8'hFF;
        step();
        chk("midrst_cur",  32'(bus_u.cur_shift), 32'd0);
        chk("midrst_ov",   32'(bus_u.out_valid), 32'd0);
        chk("midrst_dout", 32'(bus_u.data_out),  32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        step(); step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            data_in  = DATA_W'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0)  amp_sel = SHIFT_W'($urandom);
            if ($urandom_range(0, 15) == 0) ramp_en = ~ramp_en;
            rst_n = ($urandom_range(0, 79) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_amplitude_scaler
`default_nettype wire

// File: doc/amplitude_scaler.md
AMPLITUDE_SCALER -- requirements
Module: amplitude_scaler

Interface
REQ-001 Parameter DATA_W, default 8: sample width in bits.
REQ-002 Parameter SHIFT_W, default 2: width of the attenuation select; maximum attenuation is 2^SHIFT_W-1 right shifts.
REQ-003 Parameter STEP_CYCLES, default 4: clock cycles per one-step attenuation change while ramping (legal range 1 to 2^16-1).
REQ-004 Parameter SIGNED_MODE, default 0: 0 = unsigned samples with logical shift; 1 = two's-complement samples with arithmetic shift.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 data_in  input  DATA_W  input sample.
REQ-008 in_valid  input  1  data_in is valid this cycle.
REQ-009 amp_sel  input  SHIFT_W  target attenuation, in right-shift steps.
REQ-010 ramp_en  input  1  1 = glide to the target; 0 = jump to the target.
REQ-011 data_out  output  DATA_W  registered, attenuated sample.
REQ-012 out_valid  output  1  data_out was updated on the last edge.
REQ-013 cur_shift  output  SHIFT_W  attenuation currently applied.
REQ-014 settled  output  1  high when cur_shift == amp_sel and no ramp is in progress.

Function
REQ-015 On an edge with in_valid=1, data_out SHALL load data_in shifted right by the pre-edge cur_shift: zero-fill if SIGNED_MODE=0, sign-fill if SIGNED_MODE=1. Latency is 1 cycle.
REQ-016 On an edge with in_valid=0, data_out SHALL hold its value.
REQ-017 out_valid SHALL equal in_valid registered by one cycle.
REQ-018 The controller SHALL have two states, SETTLED and RAMP. Reset enters SETTLED.
REQ-019 SETTLED: if amp_sel != cur_shift and ramp_en=1, the controller SHALL enter RAMP and clear the step counter to 0. If amp_sel != cur_shift and ramp_en=0, cur_shift SHALL load amp_sel on that edge and the state SHALL stay SETTLED.
REQ-020 RAMP: the step counter SHALL increment every cycle. When it reaches STEP_CYCLES-1, the counter SHALL clear to 0 and cur_shift SHALL move one step toward the current amp_sel (+1 or -1).
REQ-021 RAMP SHALL exit to SETTLED on the edge where cur_shift becomes equal to amp_sel.
REQ-022 If amp_sel changes during RAMP, the ramp SHALL retarget without clearing the counter, and the direction SHALL be re-evaluated at each step.
REQ-023 If amp_sel equals cur_shift at a step point during RAMP, no step SHALL occur and the state SHALL return to SETTLED.
REQ-024 If ramp_en falls during RAMP, cur_shift SHALL load amp_sel on the next edge and the state SHALL return to SETTLED, with the counter cleared.
REQ-025 cur_shift SHALL never leave the range 0 to 2^SHIFT_W-1 and SHALL never wrap.
REQ-026 settled SHALL be combinational: (state == SETTLED) && (cur_shift == amp_sel).
REQ-027 Sample processing and ramp stepping on the same edge SHALL be independent; the sample uses the pre-edge cur_shift.

Reset
REQ-028 When rst_n=0 at an edge: data_out=0, out_valid=0, cur_shift=0, counter=0, state=SETTLED. Reset has priority over all other inputs.
REQ-029 A reset during RAMP SHALL abandon the ramp. The first post-reset edge SHALL treat amp_sel per REQ-019.

Structure
REQ-030 A shared package/header fg_defs SHALL hold the state encodings (SETTLED, RAMP) and the counter width constant (16), for reuse by the other function-generator blocks.
REQ-031 Ramp control (state, counter, cur_shift) SHALL live in one sub-module, shift_ramp_ctrl. The datapath shift register SHALL live in amplitude_scaler.

Verification (DATA_W=8, SHIFT_W=2, STEP_CYCLES=4)
REQ-032 Reset, then in_valid=1, data_in=0xC8, amp_sel=0 -> next cycle data_out=0xC8, out_valid=1, settled=1.
REQ-033 ramp_en=0, amp_sel 0->3 with data_in=0xC8 -> cur_shift=3 after 1 edge; the following sample gives data_out=0x19.
REQ-034 ramp_en=1, amp_sel 0->3 -> cur_shift goes 1, 2, 3 at 4-cycle intervals; settled=1 after 13 edges.
REQ-035 SIGNED_MODE=1, data_in=0x80, cur_shift=2 -> data_out=0xE0; with SIGNED_MODE=0 the same stimulus gives 0x20.
REQ-036 Ramp 0->3 retargeted to 1 when cur_shift=2 -> the next step gives cur_shift=1, then SETTLED; no step ever exceeds ±1.
REQ-037 rst_n=0 mid-ramp at cur_shift=2 -> all outputs return to reset values on the next edge; no out_valid pulse occurs.
